// File: rtl/regfile_dumper.sv
// Streams every register of the CPU register file out on a valid/ready word port,
// two registers per sweep step. Define REGDUMP_CHECKSUM_EN to append an XOR checksum word.
module regfile_dumper #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutIndex,
  output logic              OutLast
);

  localparam int PAIRS = NUM_REGS / 2;
  localparam int KW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND_A, SEND_B, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND_A, SEND_B, DONE} state_t;
`endif

  state_t            stateReg, stateNext;
  logic [KW-1:0]     kReg;
  logic [DATA_W-1:0] bufAReg, bufBReg;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksumReg;
`endif

  logic              handshake;
  logic              lastPair;
  logic [ADDR_W-1:0] evenAddr, oddAddr;

  assign handshake = OutValid && OutReady;
  assign lastPair  = (kReg == KW'(PAIRS - 1));
  assign evenAddr  = ADDR_W'({kReg, 1'b0});
  assign oddAddr   = evenAddr | ADDR_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Pair capture happens only in READ, so later file writes never reach an in-flight pair.
  always_ff @(posedge CLK) begin
    if (RST) begin
      kReg    <= '0;
      bufAReg <= '0;
      bufBReg <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      checksumReg <= '0;
`endif
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (Start) begin
            kReg <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            checksumReg <= '0;
`endif
          end
        end
        READ: begin
          bufAReg <= ReadData1;
          bufBReg <= ReadData2;
        end
        SEND_A: begin
`ifdef REGDUMP_CHECKSUM_EN
          if (handshake) checksumReg <= checksumReg ^ bufAReg;
`endif
        end
        SEND_B: begin
          if (handshake) begin
`ifdef REGDUMP_CHECKSUM_EN
            checksumReg <= checksumReg ^ bufBReg;
`endif
            if (!lastPair) kReg <= kReg + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE:   if (Start) stateNext = READ;
      READ:   stateNext = SEND_A;
      SEND_A: if (handshake) stateNext = SEND_B;
      SEND_B: begin
        if (handshake) begin
`ifdef REGDUMP_CHECKSUM_EN
          stateNext = lastPair ? CSUM : READ;
`else
          stateNext = lastPair ? DONE : READ;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM:   if (handshake) stateNext = DONE;
`endif
      DONE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    Busy     = (stateReg != IDLE);
    Done     = 1'b0;
    OutValid = 1'b0;
    OutData  = '0;
    OutIndex = '0;
    OutLast  = 1'b0;
    ReadReg1 = '0;
    ReadReg2 = '0;
    unique case (stateReg)
      READ: begin
        ReadReg1 = evenAddr;
        ReadReg2 = oddAddr;
      end
      SEND_A: begin
        ReadReg1 = evenAddr;
        ReadReg2 = oddAddr;
        OutValid = 1'b1;
        OutData  = bufAReg;
        OutIndex = evenAddr;
      end
      SEND_B: begin
        ReadReg1 = evenAddr;
        ReadReg2 = oddAddr;
        OutValid = 1'b1;
        OutData  = bufBReg;
        OutIndex = oddAddr;
`ifndef REGDUMP_CHECKSUM_EN
        OutLast  = lastPair;
`endif
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        OutValid = 1'b1;
        OutData  = checksumReg;
        OutLast  = 1'b1;
      end
`endif
      DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: each Start pushes the expected dump built from a
// snapshot of the modelled register file; a negedge monitor pops and compares on handshakes.
module tb_regfile_dumper;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif
  localparam int N = 32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic        Busy, Done, OutValid, OutLast;
  logic        OutReady = 1'b1;
  logic [4:0]  ReadReg1, ReadReg2, OutIndex;
  logic [31:0] ReadData1, ReadData2, OutData;
  logic [31:0] regFile [N];

  always #5 CLK = ~CLK;

  assign ReadData1 = regFile[ReadReg1];
  assign ReadData2 = regFile[ReadReg2];

  regfile_dumper #(.NUM_REGS(N), .ADDR_W(5), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Busy(Busy), .Done(Done),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutIndex(OutIndex),
    .OutLast(OutLast)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  idx;
    logic        last;
  } word_t;

  word_t expQ[$];
  int passCnt = 0;
  int totalCnt = 0;
  int expDone = 0;
  int doneSeen = 0;
  bit readyRandom = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: a dump is the whole file in index order, optionally followed by its XOR.
  task automatic pushDump();
    logic [31:0] x = '0;
    for (int i = 0; i < N; i++) begin
      expQ.push_back('{d: regFile[i], idx: 5'(i), last: (i == N - 1) && !CSUM_ON});
      x ^= regFile[i];
    end
    if (CSUM_ON) expQ.push_back('{d: x, idx: 5'd0, last: 1'b1});
    expDone++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseStart();
    pushDump();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic runToIdle(input int maxCyc);
    int n = 0;
    while (Busy && n < maxCyc) begin
      OutReady = readyRandom ? ($urandom_range(0, 99) < 70) : 1'b1;
      tick();
      n++;
    end
    OutReady = 1'b1;
    check("dumpTerminates", Busy, 0);
    check("queueDrained", expQ.size(), 0);
  endtask

  task automatic waitIndex(input int idx, input int maxCyc);
    int n = 0;
    while (!(OutValid && OutIndex == 5'(idx)) && n < maxCyc) begin
      tick();
      n++;
    end
    check("reachIndex", {OutValid, OutIndex}, {1'b1, 5'(idx)});
  endtask

  // Monitor: word compare on handshake, hold-stability under backpressure, Done timing.
  logic        prevHold = 1'b0;
  logic [37:0] prevWord;
  bit          doneDue = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      prevHold = 1'b0;
      doneDue  = 1'b0;
    end else begin
      if (prevHold) begin
        check("holdValid", OutValid, 1);
        check("holdWord", {OutData, OutIndex, OutLast}, prevWord);
      end
      if (doneDue || Done) check("donePulse", Done, doneDue);
      if (Done) doneSeen++;
      doneDue  = 1'b0;
      prevHold = OutValid && !OutReady;
      prevWord = {OutData, OutIndex, OutLast};
      if (OutValid && OutReady) begin
        if (expQ.size() == 0) begin
          totalCnt++;
          $display("FAIL spuriousWord: got index %0d data %0h, expected no word", OutIndex, OutData);
        end else begin
          word_t w;
          w = expQ.pop_front();
          check("word", {OutData, OutIndex, OutLast}, {w.d, w.idx, w.last});
          doneDue = w.last;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    foreach (regFile[i]) regFile[i] = '0;

    // Reset dominates Start
    Start = 1'b1;
    tick();
    tick();
    check("resetOutputs", {Busy, Done, OutValid, OutData, OutIndex, OutLast, ReadReg1, ReadReg2}, 0);
    RST = 1'b0;
    Start = 1'b0;
    repeat (3) tick();
    check("noDumpAfterReset", {Busy, OutValid}, 0);
    $display("reset: done");

    // Basic dump with timing
    regFile[1] = 32'd1; regFile[2] = 32'd2; regFile[3] = 32'd3;
    pulseStart();
    check("readCycle", {Busy, OutValid, ReadReg1, ReadReg2}, {1'b1, 1'b0, 5'd0, 5'd1});
    tick();
    check("firstValid", {OutValid, OutIndex, OutData}, {1'b1, 5'd0, 32'd0});
    cyc = 1;
    while (!Done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("doneLatency", cyc, CSUM_ON ? 49 : 48);
    tick();
    check("busyFalls", {Busy, Done}, 0);
    check("queueDrained", expQ.size(), 0);
    $display("basic dump: done after %0d cycles", cyc);

    // Backpressure at index 2
    pulseStart();
    waitIndex(2, 20);
    OutReady = 1'b0;
    repeat (5) begin
      tick();
      check("bpHold", {OutValid, OutData, OutIndex}, {1'b1, 32'd2, 5'd2});
    end
    OutReady = 1'b1;
    tick();
    check("bpResume", {OutValid, OutIndex, OutData}, {1'b1, 5'd3, 32'd3});
    runToIdle(200);
    $display("backpressure: done");

    // Write reg5 after pair (4,5) was captured; second dump sees it
    pulseStart();
    waitIndex(4, 40);
    regFile[5] = 32'hDEAD_BEEF;
    runToIdle(200);
    pulseStart();
    runToIdle(200);
    $display("mid-dump write: done");

    // Start while busy and during DONE is ignored
    pulseStart();
    repeat (10) tick();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 0;
    while (!Done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reachDone", Done, 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("startInDoneIgnored", Busy, 0);
    repeat (3) tick();
    check("stillIdle", {Busy, OutValid}, 0);
    $display("start ignored: done");

    // Reset while presenting index 10
    foreach (regFile[i]) regFile[i] = $urandom;
    pulseStart();
    waitIndex(10, 40);
    RST = 1'b1;
    expQ.delete();
    expDone--;
    tick();
    RST = 1'b0;
    check("rstMid", {OutValid, Busy, Done}, 0);
    repeat (5) tick();
    pulseStart();
    tick();
    check("restartIndex", {OutValid, OutIndex, OutData}, {1'b1, 5'd0, regFile[0]});
    runToIdle(200);
    $display("reset mid-dump: done");

    // Random files with random backpressure
    readyRandom = 1'b1;
    for (int t = 0; t < 4; t++) begin
      foreach (regFile[i]) regFile[i] = $urandom;
      pulseStart();
      runToIdle(600);
      $display("random dump %0d: done", t);
    end
    readyRandom = 1'b0;

    repeat (3) tick();
    check("doneCount", doneSeen, expDone);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Read-side sequencer for the CPU register file. On a start pulse it sweeps every register through the file's two asynchronous read ports, two registers per sweep step. It streams each value out on a valid/ready word interface for debug readout and end-of-test checking. It issues no writes and sits beside the datapath, sharing the register file's read-address muxes while the core is halted.

## Interface
- NUM_REGS, 32, registers dumped; even, 2..32
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset; synchronous, active-high
- Start  in  1  begin dump; sampled only in IDLE
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse after final word is accepted
- ReadReg1  out  ADDR_W  register file read address A (even index)
- ReadReg2  out  ADDR_W  register file read address B (odd index)
- ReadData1  in  DATA_W  register file data for ReadReg1, same cycle
- ReadData2  in  DATA_W  register file data for ReadReg2, same cycle
- OutValid  out  1  OutData/OutIndex/OutLast valid
- OutReady  in  1  consumer accepts word when OutValid && OutReady at edge
- OutData  out  DATA_W  register value
- OutIndex  out  ADDR_W  register number of OutData
- OutLast  out  1  marks final word of dump

## Operation
- States: IDLE, READ, SEND_A, SEND_B, CSUM, DONE; pair counter k in 0..NUM_REGS/2-1.
- IDLE:
  - ReadReg1=ReadReg2=0.
  - Start=1 → k=0, clear checksum, go READ.
- READ:
  - Drive ReadReg1=2k, ReadReg2=2k+1.
  - Capture ReadData1→bufA and ReadData2→bufB at the edge.
  - Go SEND_A.
- SEND_A:
  - OutValid=1, OutData=bufA, OutIndex=2k.
  - On handshake go SEND_B.
- SEND_B:
  - OutValid=1, OutData=bufB, OutIndex=2k+1.
  - On handshake: if 2k+1==NUM_REGS-1, go CSUM (macro on) or DONE; otherwise k+1, go READ.
- CSUM (macro only):
  - OutValid=1, OutData=checksum, OutIndex=0, OutLast=1.
  - On handshake go DONE.
- DONE: Done=1 for exactly one cycle, then IDLE.
- ReadReg1/ReadReg2 hold the current pair's addresses in SEND_A/SEND_B and are 0 in IDLE, CSUM and DONE.
- Valid/ready rules:
  - OutValid never drops without a handshake, except on RST.
  - OutData/OutIndex/OutLast are stable while OutValid && !OutReady.
  - OutReady is ignored when OutValid=0.
- Snapshot semantics: each pair is captured in its READ cycle. Writes to the file after that cycle are not reflected in the pair. The file as a whole is not captured atomically.
- Start while Busy (including DONE) is ignored; it is not queued.

## Timing
- Reset values: Busy=0, Done=0, OutValid=0, OutData=0, OutIndex=0, OutLast=0, ReadReg1=0, ReadReg2=0, state IDLE, k=0, checksum=0.
- Start sampled at edge n → READ during cycle n+1; first OutValid in cycle n+2.
- With OutReady held 1: one pair per 3 cycles, NUM_REGS words in 3·NUM_REGS/2 cycles.
- Done asserts the cycle after the last word's handshake edge. Busy falls together with Done's deassertion.
- RST=1 at any edge:
  - All state returns to reset values at that edge, including mid-dump.
  - The word in flight is abandoned; no Done pulse.
  - RST dominates a simultaneous Start.
- Counter wrap: k never exceeds NUM_REGS/2-1; the next Start restarts at k=0.

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - checksum = XOR of all NUM_REGS captured words, accumulated at each handshake.
  - CSUM state appends it as word NUM_REGS+1 with OutIndex=0 and OutLast=1.
  - Register NUM_REGS-1's word has OutLast=0.
- Undefined:
  - CSUM state and checksum register are absent.
  - OutLast=1 on register NUM_REGS-1's word; SEND_B goes directly to DONE.

## Test plan
- Reset: RST=1 for 2 cycles with Start=1 → all outputs 0, Busy=0, no dump starts.
- Basic dump, OutReady=1, file reg1=1, reg2=2, reg3=3, rest 0, Start pulse:
  - 32 words in index order 0..31, values 0,1,2,3,0…, first OutValid 2 cycles after Start.
  - OutLast only on index 31 (macro off), or on the 33rd word with data 0 and OutIndex 0 (macro on; 1^2^3=0).
  - Done once, 1 cycle after last handshake.
- Backpressure: OutReady=0 for 5 cycles while presenting index 2 → OutValid, OutData=2, OutIndex=2 held stable; sequence resumes at index 3 when OutReady=1.
- Mid-dump write: write reg5=0xDEAD_BEEF after pair (4,5)'s READ cycle → dump shows reg5=0; a second dump shows 0xDEADBEEF.
- Start ignored: pulse Start while Busy and again during DONE → exactly one 32-word dump, one Done.
- Reset mid-operation: RST=1 while presenting index 10 → next cycle OutValid=0, Busy=0, no Done; a new Start dumps from index 0.
